// File: rtl/switch_bounce_emulator.sv
// Switch-bounce generator: on each accepted level change it chatters pseudo-randomly
// for 2^N_BOUNCE cycles before settling on the new level; bypass mode follows cleanly.
//
// state  | meaning
// IDLE   | output steady at tgt_rg, watching for a level change
// BOUNCE | chatter window running, cnt_rg counting toward terminal value
module switch_bounce_emulator #(
  parameter int          N_BOUNCE  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sig_clean,
  input  logic i_bounce_en,
  output logic o_sig_bouncy,
  output logic o_busy,
  output logic o_done
);

  // An all-zero Galois LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0]         SEED    = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0]         TAPS    = 16'hB400;
  localparam logic [N_BOUNCE-1:0] CNT_ONE = N_BOUNCE'(1);

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t              state_rg, state_nx;
  logic                sig_rg;
  logic                tgt_rg, tgt_nx;
  logic [N_BOUNCE-1:0] cnt_rg, cnt_nx;
  logic [15:0]         lfsr_rg, lfsr_nx;
  logic                bouncy_nx, busy_nx, done_nx;

  assign lfsr_nx = lfsr_rg[0] ? ((lfsr_rg >> 1) ^ TAPS) : (lfsr_rg >> 1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_rg     <= IDLE;
      sig_rg       <= 1'b0;
      tgt_rg       <= 1'b0;
      cnt_rg       <= '0;
      lfsr_rg      <= SEED;
      o_sig_bouncy <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state_rg     <= state_nx;
      sig_rg       <= i_sig_clean;
      tgt_rg       <= tgt_nx;
      cnt_rg       <= cnt_nx;
      lfsr_rg      <= lfsr_nx;
      o_sig_bouncy <= bouncy_nx;
      o_busy       <= busy_nx;
      o_done       <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state_rg;
    tgt_nx    = tgt_rg;
    cnt_nx    = cnt_rg;
    bouncy_nx = o_sig_bouncy;
    busy_nx   = o_busy;
    done_nx   = 1'b0;
    case (state_rg)
      IDLE: begin
        bouncy_nx = tgt_rg;
        busy_nx   = 1'b0;
        if (sig_rg != tgt_rg) begin
          tgt_nx    = sig_rg;
          bouncy_nx = sig_rg;
          if (i_bounce_en) begin
            cnt_nx   = '0;
            busy_nx  = 1'b1;
            state_nx = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        // A fresh input change restarts the window even on the terminal cycle.
        if (sig_rg != tgt_rg) begin
          tgt_nx    = sig_rg;
          bouncy_nx = sig_rg;
          cnt_nx    = '0;
        end else if (cnt_rg != '1) begin
          bouncy_nx = lfsr_rg[0];
          cnt_nx    = cnt_rg + CNT_ONE;
        end else begin
          bouncy_nx = tgt_rg;
          done_nx   = 1'b1;
          busy_nx   = 1'b0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Directed bench for switch_bounce_emulator (N_BOUNCE = 3, default seed), with a
// reference Galois LFSR and a 16-cycle debouncer model for the loopback scenario.
module tb_switch_bounce_emulator;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_sig_clean = 1'b0;
  logic i_bounce_en = 1'b0;
  logic o_sig_bouncy, o_busy, o_done;

  int checks = 0;
  int failures = 0;

  switch_bounce_emulator #(.N_BOUNCE(3), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_sig_clean  (i_sig_clean),
    .i_bounce_en  (i_bounce_en),
    .o_sig_bouncy (o_sig_bouncy),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // Reference LFSR: exp_bit is the model's bit 0 as it stood just before the latest edge.
  logic [15:0] m_lfsr;
  logic        exp_bit;

  function automatic logic [15:0] m_next(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk) begin
    exp_bit <= m_lfsr[0];
    if (!rstn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_next(m_lfsr);
  end

  // Debouncer model: flips only after 16 consecutive cycles of disagreement.
  logic       deb = 1'b0;
  logic [3:0] dcnt = 4'd0;
  int         deb_tr = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      deb  <= 1'b0;
      dcnt <= 4'd0;
    end else if (o_sig_bouncy == deb) begin
      dcnt <= 4'd0;
    end else if (dcnt == 4'd15) begin
      deb    <= ~deb;
      dcnt   <= 4'd0;
      deb_tr <= deb_tr + 1;
    end else begin
      dcnt <= dcnt + 4'd1;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    rstn = 1'b0;
    i_sig_clean = 1'b1;
    i_bounce_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      obs = {o_sig_bouncy, o_busy, o_done};
      checks++;
      if (obs !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=000", c, obs);
      end
    end
    rstn = 1'b1;
    step();
    obs = {o_sig_bouncy, o_busy, o_done};
    checks++;
    if (obs !== 3'b000) begin
      failures++;
      $display("FAIL reset_e1 got=%b exp=000", obs);
    end
    step();
    obs = {o_sig_bouncy, o_busy, o_done};
    checks++;
    if (obs !== 3'b110) begin
      failures++;
      $display("FAIL reset_e2 got=%b exp=110", obs);
    end
    repeat (10) step();
  endtask

  task automatic test_bypass();
    logic [2:0] obs;
    logic       d_prev;
    i_sig_clean = 1'b0;
    i_bounce_en = 1'b0;
    do_reset(2);
    d_prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      i_sig_clean = (i >= 1 && i < 6);
      step();
      obs = {o_sig_bouncy, o_busy, o_done};
      checks++;
      if (obs !== {d_prev, 2'b00}) begin
        failures++;
        $display("FAIL bypass cyc=%0d got=%b exp=%b", i, obs, {d_prev, 2'b00});
      end
      d_prev = i_sig_clean;
    end
  endtask

  task automatic test_nominal();
    logic [2:0] obs, exp;
    i_sig_clean = 1'b0;
    i_bounce_en = 1'b1;
    do_reset(2);
    step();
    step();
    i_sig_clean = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      obs = {o_sig_bouncy, o_busy, o_done};
      if (s == 1)       exp = 3'b000;
      else if (s == 2)  exp = 3'b110;
      else if (s <= 9)  exp = {exp_bit, 2'b10};
      else if (s == 10) exp = 3'b101;
      else              exp = 3'b100;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL nominal E%0d got=%b exp=%b", s, obs, exp);
      end
    end
  endtask

  task automatic test_restart();
    logic [2:0] obs, exp;
    int         dones;
    i_sig_clean = 1'b0;
    i_bounce_en = 1'b1;
    do_reset(2);
    step();
    i_sig_clean = 1'b1;
    dones = 0;
    for (int s = 1; s <= 18; s++) begin
      step();
      obs = {o_sig_bouncy, o_busy, o_done};
      if (o_done === 1'b1) dones++;
      if (s == 1)       exp = 3'b000;
      else if (s == 2)  exp = 3'b110;
      else if (s <= 6)  exp = {exp_bit, 2'b10};
      else if (s == 7)  exp = 3'b010;
      else if (s <= 14) exp = {exp_bit, 2'b10};
      else if (s == 15) exp = 3'b001;
      else              exp = 3'b000;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL restart E%0d got=%b exp=%b", s, obs, exp);
      end
      if (s == 5) i_sig_clean = 1'b0;
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL restart_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] obs, exp;
    i_sig_clean = 1'b0;
    i_bounce_en = 1'b1;
    do_reset(2);
    step();
    step();
    i_sig_clean = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      step();
      obs = {o_sig_bouncy, o_busy, o_done};
      exp = (s == 1) ? 3'b000 : (s == 2) ? 3'b110 : {exp_bit, 2'b10};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL midrst_first E%0d got=%b exp=%b", s, obs, exp);
      end
    end
    rstn = 1'b0;
    i_sig_clean = 1'b0;
    step();
    obs = {o_sig_bouncy, o_busy, o_done};
    checks++;
    if (obs !== 3'b000) begin
      failures++;
      $display("FAIL midrst_out got=%b exp=000", obs);
    end
    rstn = 1'b1;
    step();
    step();
    i_sig_clean = 1'b1;
    for (int s = 1; s <= 11; s++) begin
      step();
      obs = {o_sig_bouncy, o_busy, o_done};
      if (s == 1)       exp = 3'b000;
      else if (s == 2)  exp = 3'b110;
      else if (s <= 9)  exp = {exp_bit, 2'b10};
      else if (s == 10) exp = 3'b101;
      else              exp = 3'b100;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL midrst_second E%0d got=%b exp=%b", s, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs;
    i_sig_clean = 1'b0;
    i_bounce_en = 1'b1;
    do_reset(2);
    step();
    i_sig_clean = 1'b1;
    repeat (10) step();
    obs = {o_sig_bouncy, o_busy, o_done};
    checks++;
    if (obs !== 3'b101) begin
      failures++;
      $display("FAIL b2b_done1 got=%b exp=101", obs);
    end
    i_sig_clean = 1'b0;
    step();
    obs = {o_sig_bouncy, o_busy, o_done};
    checks++;
    if (obs !== 3'b100) begin
      failures++;
      $display("FAIL b2b_e1 got=%b exp=100", obs);
    end
    step();
    obs = {o_sig_bouncy, o_busy, o_done};
    checks++;
    if (obs !== 3'b010) begin
      failures++;
      $display("FAIL b2b_e2 got=%b exp=010", obs);
    end
    repeat (8) step();
    obs = {o_sig_bouncy, o_busy, o_done};
    checks++;
    if (obs !== 3'b001) begin
      failures++;
      $display("FAIL b2b_done2 got=%b exp=001", obs);
    end
  endtask

  task automatic test_loopback();
    logic level;
    int   tr0;
    i_sig_clean = 1'b0;
    i_bounce_en = 1'b1;
    do_reset(2);
    step();
    level = 1'b0;
    tr0 = deb_tr;
    for (int k = 0; k < 20; k++) begin
      level = ~level;
      i_sig_clean = level;
      repeat (40) step();
      checks++;
      if (deb !== level) begin
        failures++;
        $display("FAIL loopback_level k=%0d got=%b exp=%b", k, deb, level);
      end
    end
    checks++;
    if ((deb_tr - tr0) !== 20) begin
      failures++;
      $display("FAIL loopback_transitions got=%0d exp=20", deb_tr - tr0);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_nominal();
    test_restart();
    test_mid_reset();
    test_back_to_back();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
